fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int unsigned NUM_REQ_DEF   = 4;
    localparam int unsigned WIDTH_DEF     = 32;
    localparam int unsigned MAX_BURST_DEF = 8;

    // Beat counter must hold the value MAX_BURST itself.
    function automatic int unsigned cnt_width(int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the requester/FIFO side signals around the write arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         fifo_wdata;
    logic                     fifo_wr_en;
    logic                     fifo_full;
    logic                     busy;
    logic [ID_W-1:0]          owner;

    // Requesters plus FIFO status source.
    modport master (
        output req, wdata, fifo_full,
        input  gnt, ack, fifo_wdata, fifo_wr_en, busy, owner
    );

    // Arbiter side.
    modport slave (
        input  req, wdata, fifo_full,
        output gnt, ack, fifo_wdata, fifo_wr_en, busy, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W-1:0] cand;

    // Scan upward from the pointer; the first hit wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(ptr_i) + i) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter feeding a single synchronous FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF,
    parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic [WIDTH-1:0]         fifo_wdata_o,
    output logic                     fifo_wr_en_o,
    input  logic                     fifo_full_i,
    output logic                     busy_o,
    output logic [ID_W-1:0]          owner_o
);

    localparam int unsigned     CNT_W     = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;
    logic               beat;
    logic [WIDTH-1:0]   owner_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // A beat is the owner requesting while the FIFO has room.
    assign ack_o        = gnt_q & req_i & {NUM_REQ{~fifo_full_i}};
    assign beat         = |ack_o;
    assign fifo_wr_en_o = beat;

    // Select the owner's data slice.
    always_comb begin
        owner_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == owner_q) begin
                owner_data = wdata_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign fifo_wdata_o = (state_q == GRANT) ? owner_data : '0;
    assign gnt_o        = gnt_q;
    assign owner_o      = owner_q;
    assign busy_o       = busy_q;

    // Next-state: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    gnt_d      = NUM_REQ'(1) << pick_idx;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            GRANT: begin
                if (beat && (beat_cnt_q < BURST_MAX)) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                // Owner release and burst-limit share one exit path.
                if (!req_i[owner_q] || (beat && (beat_cnt_q == LAST_BEAT))) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    owner_d  = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
        end
    end

endmodule
